// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
// State enum, LFSR seed/taps and display-select encodings.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_SHOW,
    S_FALSE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: bits 0,2,3,5 are taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Encoded as {disp_ctl0, disp_ctl1}.
  localparam logic [1:0] DISP_DEF   = 2'b00;
  localparam logic [1:0] DISP_GO    = 2'b01;
  localparam logic [1:0] DISP_SCORE = 2'b10;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [1:0] disp_sel(
    input state_t s
  );
    logic [1:0] d;
    unique case (1'b1)
      (s == S_GO):   d = DISP_GO;
      (s == S_SHOW): d = DISP_SCORE;
      default:       d = DISP_DEF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick for one cycle every N cycles.
// Ports: clk, rst_n (async low), clr (hold at zero), tick.
module ms_tick_gen #(
  parameter int N = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  assign tick = !clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random wait, GO, timed response, best score.
// Ports: clk, rst_n, start, react in; disp_ctl0/1, rt_ms, best_ms, new_best, false_start out.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS  = 50000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RT_MAX      = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        react,
  output logic        disp_ctl0,
  output logic        disp_ctl1,
  output logic [13:0] rt_ms,
  output logic [13:0] best_ms,
  output logic        new_best,
  output logic        false_start
);

  localparam int DLY_W = 16;
  localparam logic [13:0] RT_MAX_W = 14'(RT_MAX);
  localparam logic [DLY_W-1:0] MIN_W = DLY_W'(MIN_WAIT_MS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] w_dly_nxt;
  logic [DLY_W-1:0] w_dly_seed;
  logic [15:0]      r_lfsr;
  logic [13:0]      w_rt_nxt;
  logic [13:0]      w_best_nxt;
  logic             w_nb_nxt;
  logic             w_fs_nxt;
  logic             w_clr;
  logic             w_tick;

  // Prescaler only runs while a round is being timed.
  assign w_clr = !((r_state == S_WAIT) || (r_state == S_GO));

  ms_tick_gen #(
    .N(CLK_PER_MS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_dly_seed = MIN_W + {6'd0, r_lfsr[9:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_rt_nxt    = rt_ms;
    w_best_nxt  = best_ms;
    w_nb_nxt    = 1'b0;
    w_fs_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_SHOW, S_FALSE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_dly_nxt   = w_dly_seed;
        end
      end
      S_WAIT: begin
        // react is checked first so a coincident tick is dropped
        if (react) begin
          w_state_nxt = S_FALSE;
          w_fs_nxt    = 1'b1;
        end else if (w_tick) begin
          if (r_dly <= DLY_W'(1)) begin
            w_state_nxt = S_GO;
            w_dly_nxt   = '0;
            w_rt_nxt    = '0;
          end else begin
            w_dly_nxt = r_dly - 1'b1;
          end
        end
      end
      S_GO: begin
        if (react) begin
          w_state_nxt = S_SHOW;
          if (rt_ms < best_ms) begin
            w_best_nxt = rt_ms;
            w_nb_nxt   = 1'b1;
          end
        end else if (w_tick) begin
          if (rt_ms >= RT_MAX_W - 14'd1) begin
            w_rt_nxt    = RT_MAX_W;
            w_state_nxt = S_SHOW;
          end else begin
            w_rt_nxt = rt_ms + 14'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dly       <= '0;
      r_lfsr      <= LFSR_SEED;
      rt_ms       <= '0;
      best_ms     <= RT_MAX_W;
      new_best    <= 1'b0;
      false_start <= 1'b0;
      disp_ctl0   <= 1'b0;
      disp_ctl1   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dly       <= w_dly_nxt;
      r_lfsr      <= lfsr_next(r_lfsr);
      rt_ms       <= w_rt_nxt;
      best_ms     <= w_best_nxt;
      new_best    <= w_nb_nxt;
      false_start <= w_fs_nxt;
      {disp_ctl0, disp_ctl1} <= disp_sel(w_state_nxt);
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with CLK_PER_MS=4, MIN_WAIT_MS=2, RT_MAX=20.
// Random react times and wait lengths compared against a behavioural model.
module tb_reaction_ctrl;

  localparam int CPM  = 4;
  localparam int MINW = 2;
  localparam int RTM  = 20;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        react;
  logic        disp_ctl0;
  logic        disp_ctl1;
  logic [13:0] rt_ms;
  logic [13:0] best_ms;
  logic        new_best;
  logic        false_start;

  int checks;
  int errors;
  int m_best;
  logic [15:0] m_lfsr;

  reaction_ctrl #(
    .CLK_PER_MS (CPM),
    .MIN_WAIT_MS(MINW),
    .RT_MAX     (RTM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .react      (react),
    .disp_ctl0  (disp_ctl0),
    .disp_ctl1  (disp_ctl1),
    .rt_ms      (rt_ms),
    .best_ms    (best_ms),
    .new_best   (new_best),
    .false_start(false_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference random source: x^16+x^14+x^13+x^11, stepped every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                    m_lfsr[15:1]};
  end

  // Pulse start at a negedge and count negedges until GO shows.
  task automatic run_to_go(output int got, output int exp);
    exp = CPM * (MINW + int'(m_lfsr[9:0]));
    start = 1'b1;
    got = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      got++;
    end while (!(disp_ctl1 && !disp_ctl0) && got < 6000);
  endtask

  // Wait until the running time reads ms, then react.
  task automatic react_at(input int ms);
    int n;
    n = 0;
    while (int'(rt_ms) != ms && n < 200) begin
      @(negedge clk);
      n++;
    end
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
  endtask

  // Issue react at ms and check the resulting score against the model.
  task automatic scored_round(input string nm, input int ms);
    logic exp_nb;
    int   exp_best;
    exp_nb = (ms < m_best);
    exp_best = exp_nb ? ms : m_best;
    react_at(ms);
    checks++;
    if (int'(rt_ms) != ms) begin
      errors++;
      $display("FAIL %s rt_ms: got %0d exp %0d", nm, rt_ms, ms);
    end
    checks++;
    if ({disp_ctl0, disp_ctl1} !== 2'b10) begin
      errors++;
      $display("FAIL %s ctl: got %b exp 10", nm, {disp_ctl0, disp_ctl1});
    end
    checks++;
    if (new_best !== exp_nb) begin
      errors++;
      $display("FAIL %s new_best: got %b exp %b", nm, new_best, exp_nb);
    end
    checks++;
    if (int'(best_ms) != exp_best) begin
      errors++;
      $display("FAIL %s best_ms: got %0d exp %0d", nm, best_ms, exp_best);
    end
    m_best = exp_best;
    @(negedge clk);
    checks++;
    if (new_best !== 1'b0) begin
      errors++;
      $display("FAIL %s new_best_len: got %b exp 0", nm, new_best);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    react = 1'b0;
    m_best = RTM;
    repeat (3) @(negedge clk);
    checks++;
    if ({disp_ctl0, disp_ctl1, new_best, false_start} !== 4'b0000 ||
        rt_ms !== 14'd0 || int'(best_ms) != RTM) begin
      errors++;
      $display("FAIL reset: got ctl=%b nb=%b fs=%b rt=%0d best=%0d exp 00 0 0 0 %0d",
               {disp_ctl0, disp_ctl1}, new_best, false_start, rt_ms, best_ms, RTM);
    end
  endtask

  // First round starts on the first clock after reset: LFSR still at seed.
  task automatic test_wait_seed_and_normal();
    int got, exp, exp_seed;
    exp_seed = CPM * (MINW + int'(SEED & 16'h03FF));
    rst_n = 1'b1;
    run_to_go(got, exp);
    checks++;
    if (got < exp_seed - 1 || got > exp_seed + 1) begin
      errors++;
      $display("FAIL wait_seed: got %0d cycles exp %0d", got, exp_seed);
    end
    checks++;
    if (rt_ms !== 14'd0) begin
      errors++;
      $display("FAIL go_rt_clear: got %0d exp 0", rt_ms);
    end
    scored_round("normal5", 5);
  endtask

  task automatic test_false_start();
    logic [13:0] rt_before;
    rt_before = rt_ms;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    checks++;
    if (false_start !== 1'b1 || {disp_ctl0, disp_ctl1} !== 2'b00) begin
      errors++;
      $display("FAIL false_start: got fs=%b ctl=%b exp 1 00",
               false_start, {disp_ctl0, disp_ctl1});
    end
    checks++;
    if (int'(best_ms) != m_best || rt_ms !== rt_before) begin
      errors++;
      $display("FAIL fs_hold: got best=%0d rt=%0d exp %0d %0d",
               best_ms, rt_ms, m_best, rt_before);
    end
    @(negedge clk);
    checks++;
    if (false_start !== 1'b0) begin
      errors++;
      $display("FAIL fs_len: got %b exp 0", false_start);
    end
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({disp_ctl0, disp_ctl1, false_start} !== 3'b000) begin
      errors++;
      $display("FAIL fs_stay: got ctl=%b fs=%b exp 00 0",
               {disp_ctl0, disp_ctl1}, false_start);
    end
  endtask

  task automatic test_non_improve();
    int got, exp;
    run_to_go(got, exp);
    checks++;
    if (got < exp - 1 || got > exp + 1) begin
      errors++;
      $display("FAIL wait_r2: got %0d exp %0d", got, exp);
    end
    scored_round("slower7", 7);
    run_to_go(got, exp);
    scored_round("tie5", 5);
  endtask

  task automatic test_ignore();
    int got, exp;
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    @(negedge clk);
    checks++;
    if ({disp_ctl0, disp_ctl1} !== 2'b10 || int'(rt_ms) != 5 ||
        new_best !== 1'b0) begin
      errors++;
      $display("FAIL ign_react: got ctl=%b rt=%0d nb=%b exp 10 5 0",
               {disp_ctl0, disp_ctl1}, rt_ms, new_best);
    end
    run_to_go(got, exp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({disp_ctl0, disp_ctl1} !== 2'b01) begin
      errors++;
      $display("FAIL ign_start: got ctl=%b exp 01", {disp_ctl0, disp_ctl1});
    end
    scored_round("after_ign", 3);
  endtask

  task automatic test_timeout();
    int got, exp, n;
    run_to_go(got, exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({disp_ctl0, disp_ctl1} != 2'b10 && n < 500);
    checks++;
    if (n != RTM * CPM) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles exp %0d", n, RTM * CPM);
    end
    checks++;
    if (int'(rt_ms) != RTM || int'(best_ms) != m_best || new_best !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got rt=%0d best=%0d nb=%b exp %0d %0d 0",
               rt_ms, best_ms, new_best, RTM, m_best);
    end
  endtask

  task automatic test_random();
    int got, exp, ms;
    for (int i = 0; i < 6; i++) begin
      run_to_go(got, exp);
      checks++;
      if (got < exp - 1 || got > exp + 1) begin
        errors++;
        $display("FAIL wait_rand%0d: got %0d exp %0d", i, got, exp);
      end
      ms = $urandom_range(0, RTM - 1);
      scored_round($sformatf("rand%0d", i), ms);
    end
  endtask

  task automatic test_reset_mid_go();
    int got, exp;
    run_to_go(got, exp);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_best = RTM;
    checks++;
    if ({disp_ctl0, disp_ctl1, new_best, false_start} !== 4'b0000 ||
        rt_ms !== 14'd0 || int'(best_ms) != RTM) begin
      errors++;
      $display("FAIL reset_go: got ctl=%b nb=%b fs=%b rt=%0d best=%0d exp 00 0 0 0 %0d",
               {disp_ctl0, disp_ctl1}, new_best, false_start, rt_ms, best_ms, RTM);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({disp_ctl0, disp_ctl1} !== 2'b00 || int'(best_ms) != RTM) begin
      errors++;
      $display("FAIL post_reset: got ctl=%b best=%0d exp 00 %0d",
               {disp_ctl0, disp_ctl1}, best_ms, RTM);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wait_seed_and_normal();
    test_false_start();
    test_non_improve();
    test_ignore();
    test_timeout();
    test_random();
    test_reset_mid_go();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
